lsu_req_ctrl: RTL and testbench

//  Initiator side of the LSU port: sits between the execute/mem pipeline stage and the LSU.
//  - Accepts one load/store request at a time over a valid/ready handshake.
//  - Checks alignment, drives registered addr/data/WE/dtype into the LSU and waits out read latency.
//  - Returns one response per accepted request: load data, or an error flag.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_rd_assemble.sv | 30 +++
 rtl/lsu_req_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_req_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-type encoding and alignment helpers shared by the LSU,
// the decode stage and the LSU request controller.
package lsu_pkg;

  localparam int DTYPE_W        = 3;
  localparam int BYTES_PER_WORD = 4;

  // Codes 5..7 are not listed and are treated as illegal.
  typedef enum logic [DTYPE_W-1:0] {
    DT_BYTE   = 3'd0,
    DT_HALF   = 3'd1,
    DT_WORD   = 3'd2,
    DT_BYTE_U = 3'd3,
    DT_HALF_U = 3'd4
  } dtype_e;

  function automatic logic is_legal(input logic [DTYPE_W-1:0] dtype);
    return dtype <= DT_HALF_U;
  endfunction

  // Bytes are always aligned; halves need an even address; words a multiple of 4.
  function automatic logic is_aligned(input logic [DTYPE_W-1:0] dtype,
                                      input logic [1:0]         addr_lsbs);
    case (dtype)
      DT_HALF, DT_HALF_U: return !addr_lsbs[0];
      DT_WORD:            return addr_lsbs == 2'b00;
      default:            return 1'b1;
    endcase
  endfunction

  // Number of byte beats an access needs when it is split into single bytes.
  function automatic logic [2:0] beats_for(input logic [DTYPE_W-1:0] dtype);
    case (dtype)
      DT_HALF, DT_HALF_U: return 3'd2;
      DT_WORD:            return 3'(BYTES_PER_WORD);
      default:            return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rd_assemble.sv
// lsu_rd_assemble: merges one returned byte into the partially built load
// word at its little-endian lane and sign/zero extends the merged result.
module lsu_rd_assemble
  import lsu_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  idx_i,
  input  dtype_e      dtype_i,
  output logic [31:0] merged_o,
  output logic [31:0] ext_o
);

  // Drop the new byte into lane idx_i of the bytes collected so far.
  always_comb begin
    merged_o = acc_i;
    merged_o[8*idx_i +: 8] = byte_i;
  end

  // Extend from the access width; a word needs no extension.
  always_comb begin
    ext_o = merged_o;
    case (dtype_i)
      DT_HALF:   ext_o = {{16{merged_o[15]}}, merged_o[15:0]};
      DT_HALF_U: ext_o = {16'h0000, merged_o[15:0]};
      default:   ext_o = merged_o;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: initiator side of the LSU port. Takes one request at a time,
// checks it, drives registered LSU inputs, waits out read latency and returns
// one response per accepted request.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned half/word
// accesses into byte beats instead of returning an error).
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_SPACE  = 4096,
  parameter int NUM_DATA_TYPES = 6,
  parameter int RD_LATENCY     = 1,
  localparam int AW            = $clog2(ADDRESS_SPACE),
  localparam int DTW           = $clog2(NUM_DATA_TYPES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_we_i,
  input  logic [DTW-1:0]        req_dtype_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [AW-1:0]         lsu_addr_o,
  output logic [DATA_WIDTH-1:0] lsu_data_o,
  output logic                  lsu_we_o,
  output logic [DTW-1:0]        lsu_dtype_o,
  input  logic [DATA_WIDTH-1:0] lsu_data_i
);

  localparam int LCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  // Stores go ISSUE -> ISSUE per beat -> RESP; loads go ISSUE -> WAIT per beat.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   lat_cnt_q;
  logic [1:0]       beat_cnt_q, last_beat_q, next_beat;
  logic             we_q, split_q;
  logic             accept, req_ok, need_split, lat_done, last_beat, rd_advance;
  logic [7:0]       next_store_byte;
  logic [31:0]      split_rdata;

  assign req_ok     = is_legal(req_dtype_i) &&
                      (SPLIT_EN || is_aligned(req_dtype_i, req_addr_i[1:0]));
  assign need_split = SPLIT_EN && !is_aligned(req_dtype_i, req_addr_i[1:0]);
  assign lat_done   = lat_cnt_q == LCW'(RD_LATENCY - 1);
  assign last_beat  = beat_cnt_q == last_beat_q;
  assign next_beat  = beat_cnt_q + 2'd1;
  assign rd_advance = (state_q == WAIT) && lat_done && !last_beat;

  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; illegal or unsplittable requests go straight to RESP.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = req_ok ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (we_q) state_d = last_beat ? RESP : ISSUE;
        else      state_d = WAIT;
      end
      WAIT: begin
        if (lat_done) state_d = last_beat ? RESP : ISSUE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LSU drive registers, beat/latency counters and the response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_addr_o  <= '0;
      lsu_data_o  <= '0;
      lsu_we_o    <= 1'b0;
      lsu_dtype_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      lat_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      last_beat_q <= '0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_err_o   <= !req_ok;
            rsp_rdata_o <= '0;
            lat_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            we_q        <= req_we_i;
            split_q     <= need_split;
            if (req_ok) begin
              lsu_addr_o <= req_addr_i;
              lsu_we_o   <= req_we_i;
              if (need_split) begin
                lsu_dtype_o <= DT_BYTE_U;
                lsu_data_o  <= {{(DATA_WIDTH-8){1'b0}}, req_wdata_i[7:0]};
                last_beat_q <= 2'(beats_for(req_dtype_i) - 3'd1);
              end else begin
                lsu_dtype_o <= req_dtype_i;
                lsu_data_o  <= req_wdata_i;
                last_beat_q <= '0;
              end
            end
          end
        end
        ISSUE: begin
          lat_cnt_q <= '0;
          if (we_q) begin
            if (last_beat) begin
              lsu_we_o <= 1'b0;
            end else begin
              beat_cnt_q <= next_beat;
              lsu_addr_o <= lsu_addr_o + AW'(1);
              lsu_data_o <= {{(DATA_WIDTH-8){1'b0}}, next_store_byte};
            end
          end
        end
        WAIT: begin
          if (lat_done) begin
            lat_cnt_q <= '0;
            if (last_beat) begin
              rsp_rdata_o <= split_q ? split_rdata : lsu_data_i;
            end else begin
              beat_cnt_q <= next_beat;
              lsu_addr_o <= lsu_addr_o + AW'(1);
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + LCW'(1);
          end
        end
        RESP: begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] wdata_q, acc_q, asm_merged;
  dtype_e      dtype_q;

  // Keep the original store data and type, and collect load bytes per beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q <= '0;
      acc_q   <= '0;
      dtype_q <= DT_BYTE;
    end else if (accept) begin
      wdata_q <= req_wdata_i;
      acc_q   <= '0;
      dtype_q <= dtype_e'(req_dtype_i);
    end else if (rd_advance) begin
      acc_q <= asm_merged;
    end
  end

  assign next_store_byte = wdata_q[8*next_beat +: 8];

  lsu_rd_assemble u_rd_assemble (
    .acc_i    (acc_q),
    .byte_i   (lsu_data_i[7:0]),
    .idx_i    (beat_cnt_q),
    .dtype_i  (dtype_q),
    .merged_o (asm_merged),
    .ext_o    (split_rdata)
  );
`else
  assign next_store_byte = rd_advance ? 8'h00 : 8'h00;
  assign split_rdata     = '0;
`endif

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: directed test of the LSU request controller against a
// small byte-addressed LSU memory model with one cycle of read latency.
module tb_lsu_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_we_i;
  logic [2:0]  req_dtype_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [11:0] lsu_addr_o;
  logic [31:0] lsu_data_o;
  logic        lsu_we_o;
  logic [2:0]  lsu_dtype_o;
  logic [31:0] lsu_data_i;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] addrAt  [0:31];
  logic [31:0] dataAt  [0:31];
  logic [2:0]  dtypeAt [0:31];
  int          rspCycle;
  logic [31:0] rspData;
  logic        rspErr;

  lsu_req_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_we_i    (req_we_i),
    .req_dtype_i (req_dtype_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .lsu_addr_o  (lsu_addr_o),
    .lsu_data_o  (lsu_data_o),
    .lsu_we_o    (lsu_we_o),
    .lsu_dtype_o (lsu_dtype_o),
    .lsu_data_i  (lsu_data_i)
  );

  always #5 clk = ~clk;

  // LSU model read: little-endian bytes, extension by access type.
  function automatic logic [31:0] lsuRead(input logic [11:0] a, input logic [2:0] dt);
    logic [11:0] a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    a1 = a + 12'd1; a2 = a + 12'd2; a3 = a + 12'd3;
    b0 = mem[a]; b1 = mem[a1]; b2 = mem[a2]; b3 = mem[a3];
    case (dt)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      3'd3:    return {24'h0, b0};
      3'd4:    return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  // LSU model: write on WE, and return read data one cycle after sampling.
  always @(posedge clk) begin
    if (lsu_we_o) begin
      case (lsu_dtype_o)
        3'd0, 3'd3: mem[lsu_addr_o] = lsu_data_o[7:0];
        3'd1, 3'd4: begin
          mem[lsu_addr_o]         = lsu_data_o[7:0];
          mem[lsu_addr_o + 12'd1] = lsu_data_o[15:8];
        end
        3'd2: begin
          mem[lsu_addr_o]         = lsu_data_o[7:0];
          mem[lsu_addr_o + 12'd1] = lsu_data_o[15:8];
          mem[lsu_addr_o + 12'd2] = lsu_data_o[23:16];
          mem[lsu_addr_o + 12'd3] = lsu_data_o[31:24];
        end
        default: ;
      endcase
    end
    lsu_data_i <= lsuRead(lsu_addr_o, lsu_dtype_o);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One request: offer it, record LSU outputs per cycle after acceptance,
  // and check response timing, data, error flag and number of store beats.
  task automatic applyStimulus(input string tag, input logic [11:0] addr, input logic we,
                               input logic [2:0] dtype, input logic [31:0] wdata,
                               input int expCycle, input logic [31:0] expData,
                               input logic expErr, input int expWe);
    int weCount;
    weCount  = 0;
    rspCycle = 0;
    @(negedge clk);
    checkOutput({tag, "_ready_idle"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_dtype_i = dtype;
    req_wdata_i = wdata;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      addrAt[c]  = lsu_addr_o;
      dataAt[c]  = lsu_data_o;
      dtypeAt[c] = lsu_dtype_o;
      if (lsu_we_o) weCount++;
      if (c == 1) checkOutput({tag, "_ready_busy"}, {31'b0, req_ready_o}, 32'd0);
      if (rsp_valid_o) begin
        rspCycle = c;
        rspData  = rsp_rdata_o;
        rspErr   = rsp_err_o;
        break;
      end
    end
    checkOutput({tag, "_rsp_cycle"}, rspCycle, expCycle);
    checkOutput({tag, "_rdata"}, rspData, expData);
    checkOutput({tag, "_err"}, {31'b0, rspErr}, {31'b0, expErr});
    checkOutput({tag, "_we_beats"}, weCount, expWe);
    @(negedge clk);
    checkOutput({tag, "_ready_after"}, {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    int sawRsp, firstWe, rspA, rspB, bAcc;
    logic [31:0] dataA;
    logic [11:0] addrC3;
    logic        readyC2;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h013] = 8'h80;
    mem[12'h001] = 8'h34;
    mem[12'h002] = 8'h92;

    reset = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_we_i = 1'b0; req_dtype_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_we", {31'b0, lsu_we_o}, 32'd0);
    checkOutput("rst_addr", {20'b0, lsu_addr_o}, 32'd0);
    checkOutput("rst_data", lsu_data_o, 32'd0);
    checkOutput("rst_dtype", {29'b0, lsu_dtype_o}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
    checkOutput("rst_err", {31'b0, rsp_err_o}, 32'd0);
    reset = 1'b0;

    // Reset held three cycles in the middle of a load aborts it silently.
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 12'h010; req_we_i = 1'b0; req_dtype_i = 3'd2;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    reset = 1'b1;
    sawRsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid_o) sawRsp++;
    end
    reset = 1'b0;
    checkOutput("rstmid_we", {31'b0, lsu_we_o}, 32'd0);
    checkOutput("rstmid_ready", {31'b0, req_ready_o}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid_o) sawRsp++;
    end
    checkOutput("rstmid_no_rsp", sawRsp, 32'd0);

    // Byte loads, signed and unsigned.
    applyStimulus("ld_byte", 12'h013, 1'b0, 3'd0, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0);
    checkOutput("ld_byte_addr", {20'b0, addrAt[1]}, 32'h013);
    checkOutput("ld_byte_dtype", {29'b0, dtypeAt[1]}, 32'd0);
    applyStimulus("ld_byteu", 12'h013, 1'b0, 3'd3, 32'h0, 3, 32'h00000080, 1'b0, 0);

    // Word store then load back.
    applyStimulus("st_word", 12'h010, 1'b1, 3'd2, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    checkOutput("st_word_addr", {20'b0, addrAt[1]}, 32'h010);
    checkOutput("st_word_data", dataAt[1], 32'hDEADBEEF);
    applyStimulus("ld_word", 12'h010, 1'b0, 3'd2, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);
    applyStimulus("ld_half", 12'h012, 1'b0, 3'd1, 32'h0, 3, 32'hFFFFDEAD, 1'b0, 0);
    applyStimulus("ld_halfu", 12'h012, 1'b0, 3'd4, 32'h0, 3, 32'h0000DEAD, 1'b0, 0);

    // Misaligned half load and misaligned word store with wrap-around.
`ifdef LSU_MISALIGN_SPLIT_EN
    applyStimulus("ld_mis_half", 12'h001, 1'b0, 3'd1, 32'h0, 5, 32'hFFFF9234, 1'b0, 0);
    checkOutput("ld_mis_beat0", {20'b0, addrAt[1]}, 32'h001);
    checkOutput("ld_mis_beat1", {20'b0, addrAt[3]}, 32'h002);
    checkOutput("ld_mis_dtype", {29'b0, dtypeAt[1]}, 32'd3);
    applyStimulus("st_mis_word", 12'hFFF, 1'b1, 3'd2, 32'hA1B2C3D4, 5, 32'h0, 1'b0, 4);
    checkOutput("st_mis_a0", {20'b0, addrAt[1]}, 32'hFFF);
    checkOutput("st_mis_a1", {20'b0, addrAt[2]}, 32'h000);
    checkOutput("st_mis_a2", {20'b0, addrAt[3]}, 32'h001);
    checkOutput("st_mis_a3", {20'b0, addrAt[4]}, 32'h002);
    checkOutput("st_mis_d0", dataAt[1], 32'h000000D4);
    checkOutput("st_mis_d1", dataAt[2], 32'h000000C3);
    checkOutput("st_mis_d2", dataAt[3], 32'h000000B2);
    checkOutput("st_mis_d3", dataAt[4], 32'h000000A1);
    applyStimulus("ld_after_split", 12'h000, 1'b0, 3'd2, 32'h0, 3, 32'h00A1B2C3, 1'b0, 0);
`else
    applyStimulus("ld_mis_half", 12'h001, 1'b0, 3'd1, 32'h0, 1, 32'h0, 1'b1, 0);
    checkOutput("ld_mis_addr_held", {20'b0, addrAt[1]}, 32'h012);
    checkOutput("ld_mis_dtype_held", {29'b0, dtypeAt[1]}, 32'd4);
    applyStimulus("st_mis_word", 12'hFFF, 1'b1, 3'd2, 32'hA1B2C3D4, 1, 32'h0, 1'b1, 0);
    applyStimulus("ld_after_err", 12'h000, 1'b0, 3'd2, 32'h0, 3, 32'h00923400, 1'b0, 0);
`endif

    // Illegal access types.
    applyStimulus("ill_dt6", 12'h020, 1'b1, 3'b110, 32'h12345678, 1, 32'h0, 1'b1, 0);
    applyStimulus("ill_dt7", 12'h020, 1'b0, 3'b111, 32'h0, 1, 32'h0, 1'b1, 0);

    // Back-to-back: second request held valid is taken only after the first response.
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 12'h010; req_we_i = 1'b0; req_dtype_i = 3'd2;
    @(posedge clk);
    #1 req_addr_i = 12'h020; req_we_i = 1'b1; req_wdata_i = 32'h00005A5A;
    firstWe = 0; rspA = 0; rspB = 0; bAcc = 0; dataA = '0; addrC3 = '0; readyC2 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) readyC2 = req_ready_o;
      if (c == 3) addrC3 = lsu_addr_o;
      if (lsu_we_o && firstWe == 0) firstWe = c;
      if (rsp_valid_o) begin
        if (rspA == 0) begin rspA = c; dataA = rsp_rdata_o; end
        else if (rspB == 0) rspB = c;
      end
      if (rspB != 0) break;
      if (req_ready_o && req_valid_i && bAcc == 0) begin
        bAcc = c;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
      end
    end
    req_valid_i = 1'b0;
    checkOutput("b2b_ready_busy", {31'b0, readyC2}, 32'd0);
    checkOutput("b2b_addr_held", {20'b0, addrC3}, 32'h010);
    checkOutput("b2b_rspA_cycle", rspA, 32'd3);
    checkOutput("b2b_rspA_data", dataA, 32'hDEADBEEF);
    checkOutput("b2b_accB_cycle", bAcc, 32'd4);
    checkOutput("b2b_weB_cycle", firstWe, 32'd5);
    checkOutput("b2b_rspB_cycle", rspB, 32'd6);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
